// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : shared VGA constants, colour type, pixel classes and clog2 helper
// Revision : 1.0
// ============================================================================
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb9_t;

  localparam rgb9_t COLOR_BLACK = '{r: 3'd0, g: 3'd0, b: 3'd0};
  localparam rgb9_t COLOR_BG    = '{r: 3'd0, g: 3'd0, b: 3'd1};
  localparam rgb9_t COLOR_GRID  = '{r: 3'd7, g: 3'd7, b: 3'd7};

  typedef enum logic [1:0] {
    PIX_BLANK = 2'd0,
    PIX_BG    = 2'd1,
    PIX_GRID  = 2'd2,
    PIX_CELL  = 2'd3
  } pix_class_t;

  typedef enum logic [0:0] {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  // Never returns less than 1 so it can size a port directly.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_frame_buffer.sv
`default_nettype none
// ============================================================================
// matrix_frame_buffer : two N*N element banks, back-bank write port,
//                       registered front-bank read port and front selector
// Revision : 1.0
// ============================================================================
module matrix_frame_buffer
  import vga_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [clog2(N*N)-1:0]    wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     swap,
  input  logic [clog2(N*N)-1:0]    rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     front_sel
);

  localparam int DEPTH = N * N;

  logic [DATA_W-1:0] r_bank0 [DEPTH];
  logic [DATA_W-1:0] r_bank1 [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_front_sel;
  logic              w_wr_ok;

  assign w_wr_ok = wr_en && (32'(wr_addr) < 32'(DEPTH));

  // Write targets the back bank as selected before any toggle on this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
      r_front_sel <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      if (w_wr_ok) begin
        if (r_front_sel) r_bank0[wr_addr] <= wr_data;
        else             r_bank1[wr_addr] <= wr_data;
      end
      if (swap) r_front_sel <= ~r_front_sel;
      r_rd_data <= r_front_sel ? r_bank1[rd_addr] : r_bank0[rd_addr];
    end
  end

  assign rd_data   = r_rd_data;
  assign front_sel = r_front_sel;

endmodule
`default_nettype wire

// File: rtl/matrix_grid_renderer.sv
`default_nettype none
// ============================================================================
// matrix_grid_renderer : renders an N x N matrix as a heat-coloured cell grid
//                        with a 3-cycle pixel pipeline and frame-synced swap
// Revision : 1.0
// ============================================================================
module matrix_grid_renderer
  import vga_pkg::*;
#(
  parameter int N        = 4,
  parameter int DATA_W   = 8,
  parameter int CELL_PX  = 64,
  parameter int ORIGIN_X = 64,
  parameter int ORIGIN_Y = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [9:0]            in_x,
  input  logic [9:0]            in_y,
  input  logic                  in_active,
  input  logic                  in_hsync,
  input  logic                  in_vsync,
  input  logic                  wr_en,
  input  logic [clog2(N*N)-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  front_sel,
  output logic                  hsync,
  output logic                  vsync,
  output logic [2:0]            red,
  output logic [2:0]            green,
  output logic [2:0]            blue
);

  localparam int ADDR_W  = clog2(N * N);
  localparam int CELL_SH = clog2(CELL_PX);
  localparam int GRID_PX = N * CELL_PX;

  // ---------------------------------------------------------------- geometry
  logic [11:0]       w_ox;
  logic [11:0]       w_oy;
  logic              w_in_x;
  logic              w_in_y;
  logic              w_line;
  logic [ADDR_W-1:0] w_addr;
  pix_class_t        w_class;

  // Widened so a pixel left of / above the origin shows up as a set MSB.
  assign w_ox   = {2'b00, in_x} - 12'(ORIGIN_X);
  assign w_oy   = {2'b00, in_y} - 12'(ORIGIN_Y);
  assign w_in_x = !w_ox[11] && (w_ox <= 12'(GRID_PX));
  assign w_in_y = !w_oy[11] && (w_oy <= 12'(GRID_PX));
  assign w_line = (w_ox[CELL_SH-1:0] == '0) || (w_oy[CELL_SH-1:0] == '0) ||
                  (w_ox == 12'(GRID_PX)) || (w_oy == 12'(GRID_PX));
  assign w_addr = ADDR_W'(32'(w_oy >> CELL_SH) * N + 32'(w_ox >> CELL_SH));

  always_comb begin
    w_class = PIX_BLANK;
    if (in_active) begin
      if (!(w_in_x && w_in_y)) w_class = PIX_BG;
      else if (w_line)         w_class = PIX_GRID;
      else                     w_class = PIX_CELL;
    end
  end

  // ---------------------------------------------------------------- swap FSM
  swap_state_t r_state;
  logic        r_vsync_prev;
  logic        r_swap_ack;
  logic        w_frame_start;
  logic        w_swap;

  assign w_frame_start = r_vsync_prev && !in_vsync;
  assign w_swap        = (r_state == SWAP_PENDING) && w_frame_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= SWAP_IDLE;
      r_vsync_prev <= 1'b1;
      r_swap_ack   <= 1'b0;
    end else begin
      r_vsync_prev <= in_vsync;
      r_swap_ack   <= 1'b0;
      case (r_state)
        SWAP_IDLE: begin
          if (swap_req) r_state <= SWAP_PENDING;
        end
        SWAP_PENDING: begin
          if (w_frame_start) begin
            r_state    <= SWAP_IDLE;
            r_swap_ack <= 1'b1;
          end
        end
        default: r_state <= SWAP_IDLE;
      endcase
    end
  end

  assign swap_ack = r_swap_ack;

  // ------------------------------------------------------------ frame buffer
  logic [DATA_W-1:0] w_rd_data;
  logic [ADDR_W-1:0] r_s0_addr;

  matrix_frame_buffer #(
    .N      (N),
    .DATA_W (DATA_W)
  ) u_frame_buffer (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .swap      (w_swap),
    .rd_addr   (r_s0_addr),
    .rd_data   (w_rd_data),
    .front_sel (front_sel)
  );

  // Only the top three bits drive colour; the rest are stored but not shown.
  logic w_unused_rd_bits;
  assign w_unused_rd_bits = ^w_rd_data;

  // ---------------------------------------------------------------- pipeline
  pix_class_t r_s0_class;
  pix_class_t r_s1_class;
  logic       r_s0_hsync;
  logic       r_s0_vsync;
  logic       r_s1_hsync;
  logic       r_s1_vsync;
  logic       r_hsync;
  logic       r_vsync;
  rgb9_t      r_rgb;
  rgb9_t      w_rgb;
  logic [2:0] w_v3;

  always_comb begin
    w_v3  = w_rd_data[DATA_W-1 -: 3];
    w_rgb = COLOR_BLACK;
    case (r_s1_class)
      PIX_BLANK: w_rgb = COLOR_BLACK;
      PIX_BG:    w_rgb = COLOR_BG;
      PIX_GRID:  w_rgb = COLOR_GRID;
      PIX_CELL:  w_rgb = '{r: w_v3, g: 3'd7 - w_v3, b: 3'd0};
      default:   w_rgb = COLOR_BLACK;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s0_class <= PIX_BLANK;
      r_s0_addr  <= '0;
      r_s0_hsync <= 1'b1;
      r_s0_vsync <= 1'b1;
      r_s1_class <= PIX_BLANK;
      r_s1_hsync <= 1'b1;
      r_s1_vsync <= 1'b1;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_rgb      <= COLOR_BLACK;
    end else begin
      r_s0_class <= w_class;
      r_s0_addr  <= w_addr;
      r_s0_hsync <= in_hsync;
      r_s0_vsync <= in_vsync;
      r_s1_class <= r_s0_class;
      r_s1_hsync <= r_s0_hsync;
      r_s1_vsync <= r_s0_vsync;
      r_hsync    <= r_s1_hsync;
      r_vsync    <= r_s1_vsync;
      r_rgb      <= w_rgb;
    end
  end

  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign red   = r_rgb.r;
  assign green = r_rgb.g;
  assign blue  = r_rgb.b;

endmodule
`default_nettype wire

// File: tb/tb_matrix_grid_renderer.sv
`default_nettype none
// ============================================================================
// tb_matrix_grid_renderer : directed pixel tables plus swap handshake sequences
// Revision : 1.0
// ============================================================================
module tb_matrix_grid_renderer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] in_x = '0;
  logic [9:0] in_y = '0;
  logic       in_active = 1'b0;
  logic       in_hsync = 1'b1;
  logic       in_vsync = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       swap_req = 1'b0;
  logic       swap_ack;
  logic       front_sel;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [2:0] blue;

  int checks = 0;
  int errors = 0;

  matrix_grid_renderer #(
    .N        (4),
    .DATA_W   (8),
    .CELL_PX  (64),
    .ORIGIN_X (64),
    .ORIGIN_Y (64)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_active (in_active),
    .in_hsync  (in_hsync),
    .in_vsync  (in_vsync),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack),
    .front_sel (front_sel),
    .hsync     (hsync),
    .vsync     (vsync),
    .red       (red),
    .green     (green),
    .blue      (blue)
  );

  always #5 clk = ~clk;

  // rgb packed as 9'o<r><g><b>
  typedef struct {
    int       x;
    int       y;
    bit       act;
    bit [8:0] rgb;
  } pix_vec_t;

  pix_vec_t pre_vecs[11];
  pix_vec_t post_vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rgb(input string name, input bit [8:0] exp);
    checks++;
    if ({red, green, blue} !== exp) begin
      errors++;
      $display("FAIL %s: got rgb %o%o%o expected rgb %03o", name, red, green, blue, exp);
    end
  endtask

  task automatic pixel(input int x, input int y, input bit act, input bit [8:0] exp,
                       input string name);
    @(negedge clk);
    in_x      = 10'(x);
    in_y      = 10'(y);
    in_active = act;
    repeat (3) @(posedge clk);
    #1;
    check_rgb(name, exp);
  endtask

  task automatic write_elem(input int addr, input bit [7:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic pulse_req();
    @(negedge clk);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  // Drops in_vsync for three cycles and counts swap_ack pulses.
  task automatic vsync_window(input bit req_on_edge, output int acks);
    acks = 0;
    @(negedge clk);
    in_vsync = 1'b0;
    swap_req = req_on_edge;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (swap_ack) acks++;
      swap_req = 1'b0;
      if (i == 2) in_vsync = 1'b1;
    end
  endtask

  task automatic sync_latency(input bit is_v);
    logic [3:0] seen;
    seen = '0;
    @(negedge clk);
    if (is_v) in_vsync = 1'b0;
    else      in_hsync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      seen[i]  = is_v ? vsync : hsync;
      in_hsync = 1'b1;
      in_vsync = 1'b1;
    end
    check(is_v ? "vsync_latency" : "hsync_latency", int'(seen), int'(4'b1011));
  endtask

  initial begin
    int acks;

    pre_vecs[0]  = '{70,  70,  1'b1, 9'o070};
    pre_vecs[1]  = '{200, 140, 1'b1, 9'o070};
    pre_vecs[2]  = '{192, 140, 1'b1, 9'o777};
    pre_vecs[3]  = '{320, 320, 1'b1, 9'o777};
    pre_vecs[4]  = '{64,  100, 1'b1, 9'o777};
    pre_vecs[5]  = '{100, 64,  1'b1, 9'o777};
    pre_vecs[6]  = '{10,  10,  1'b1, 9'o001};
    pre_vecs[7]  = '{63,  100, 1'b1, 9'o001};
    pre_vecs[8]  = '{321, 100, 1'b1, 9'o001};
    pre_vecs[9]  = '{200, 140, 1'b0, 9'o000};
    pre_vecs[10] = '{130, 130, 1'b1, 9'o070};

    post_vecs[0] = '{200, 140, 1'b1, 9'o700};
    post_vecs[1] = '{70,  70,  1'b1, 9'o700};
    post_vecs[2] = '{130, 130, 1'b1, 9'o340};
    post_vecs[3] = '{130, 70,  1'b1, 9'o070};
    post_vecs[4] = '{255, 255, 1'b1, 9'o070};
    post_vecs[5] = '{319, 319, 1'b1, 9'o070};
    post_vecs[6] = '{320, 200, 1'b0, 9'o000};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_rgb("reset_rgb", 9'o000);
    check("reset_hsync", int'(hsync), 1);
    check("reset_vsync", int'(vsync), 1);
    check("reset_front_sel", int'(front_sel), 0);
    check("reset_swap_ack", int'(swap_ack), 0);

    write_elem(0, 8'hFF);
    write_elem(6, 8'hE0);
    write_elem(5, 8'h60);

    for (int i = 0; i < 11; i++)
      pixel(pre_vecs[i].x, pre_vecs[i].y, pre_vecs[i].act, pre_vecs[i].rgb,
            $sformatf("pre_pixel_%0d", i));

    sync_latency(1'b0);
    sync_latency(1'b1);
    check("no_req_front_sel", int'(front_sel), 0);

    pulse_req();
    vsync_window(1'b0, acks);
    check("swap_ack_count", acks, 1);
    check("swap_front_sel", int'(front_sel), 1);

    for (int i = 0; i < 7; i++)
      pixel(post_vecs[i].x, post_vecs[i].y, post_vecs[i].act, post_vecs[i].rgb,
            $sformatf("post_pixel_%0d", i));

    // Second request while already pending must not queue another swap.
    @(negedge clk); swap_req = 1'b1;
    @(negedge clk); swap_req = 1'b0;
    @(negedge clk); swap_req = 1'b1;
    @(negedge clk); swap_req = 1'b0;
    vsync_window(1'b0, acks);
    check("double_req_acks", acks, 1);
    check("double_req_front_sel", int'(front_sel), 0);
    vsync_window(1'b0, acks);
    check("double_req_no_second_ack", acks, 0);
    pixel(200, 140, 1'b1, 9'o070, "front0_pixel");

    // Request on the boundary cycle is serviced one frame later.
    vsync_window(1'b1, acks);
    check("edge_req_first_acks", acks, 0);
    check("edge_req_first_front", int'(front_sel), 0);
    vsync_window(1'b0, acks);
    check("edge_req_second_acks", acks, 1);
    check("edge_req_second_front", int'(front_sel), 1);
    pixel(200, 140, 1'b1, 9'o700, "retained_back_pixel");

    // Reset while pending, checked between clock edges.
    pulse_req();
    @(negedge clk);
    in_x      = 10'd192;
    in_y      = 10'd140;
    in_active = 1'b1;
    in_hsync  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_rgb("pre_reset_rgb", 9'o777);
    check("pre_reset_hsync", int'(hsync), 0);
    check("pre_reset_front_sel", int'(front_sel), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_rgb("async_reset_rgb", 9'o000);
    check("async_reset_hsync", int'(hsync), 1);
    check("async_reset_vsync", int'(vsync), 1);
    check("async_reset_swap_ack", int'(swap_ack), 0);
    check("async_reset_front_sel", int'(front_sel), 0);
    @(negedge clk);
    reset_n   = 1'b1;
    in_hsync  = 1'b1;
    in_active = 1'b0;
    vsync_window(1'b0, acks);
    check("reset_drop_acks", acks, 0);
    check("reset_drop_front_sel", int'(front_sel), 0);

    // Both banks were cleared by reset.
    pulse_req();
    vsync_window(1'b0, acks);
    check("post_reset_swap_acks", acks, 1);
    pixel(200, 140, 1'b1, 9'o070, "cleared_bank_pixel");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_grid_renderer.md
Name: matrix_grid_renderer

Overview:
Pixel-source stage between the VGA timing generator and the RGB output pins. It renders an N x N matrix of result values as a grid of coloured cells, with values mapped to a red/green heat colour. Storage is double-buffered: the matrix engine writes the back buffer, and the buffers swap only at a frame boundary through a request/acknowledge handshake. Timing inputs pass through a fixed 3-cycle pipeline so that sync stays aligned with colour.

Parameters:
N, 4, matrix dimension (cells per row and per column)
DATA_W, 8, element width; must be >= 3
CELL_PX, 64, cell edge length in pixels; must be a power of two
ORIGIN_X, 64, x of the grid's top-left pixel
ORIGIN_Y, 64, y of the grid's top-left pixel

Ports:
clk  in  1  pixel clock (25 MHz)
reset_n  in  1  asynchronous, active-low reset
in_x  in  10  pixel column from the timing generator
in_y  in  10  pixel row from the timing generator
in_active  in  1  active-video flag
in_hsync  in  1  horizontal sync, active-low
in_vsync  in  1  vertical sync, active-low
wr_en  in  1  back-buffer write strobe
wr_addr  in  $clog2(N*N)  element index, row*N+col
wr_data  in  DATA_W  element value (unsigned)
swap_req  in  1  single-cycle pulse requesting a buffer swap
swap_ack  out  1  single-cycle pulse when the swap takes effect
front_sel  out  1  index of the buffer currently displayed
hsync  out  1  delayed in_hsync
vsync  out  1  delayed in_vsync
red  out  3  red channel
green  out  3  green channel
blue  out  3  blue channel

Behaviour:
- Reset (async assert, sync release) clears:
  - red, green, blue to 0
  - hsync, vsync to 1
  - swap_ack, front_sel, swap-pending flag to 0
  - all elements of both buffers to 0
- Pipeline: S0 registers inputs and classifies the pixel. S1 performs the registered buffer read. S2 registers the colour map. hsync, vsync and active are delayed by exactly 3 cycles.
- Geometry:
  - ox = in_x - ORIGIN_X, oy = in_y - ORIGIN_Y.
  - Inside the grid when 0 <= ox <= N*CELL_PX and 0 <= oy <= N*CELL_PX.
  - Grid-line pixel: inside, and (ox mod CELL_PX == 0, or oy mod CELL_PX == 0, or ox == N*CELL_PX, or oy == N*CELL_PX).
  - Otherwise a cell pixel: col = ox / CELL_PX, row = oy / CELL_PX, addr = row*N + col.
- Colour, by class:
  - Not active: 0/0/0.
  - Active, outside the grid: 0/0/1 (background).
  - Grid line: 7/7/7.
  - Cell: v3 = v[DATA_W-1 -: 3]; red = v3, green = 7 - v3, blue = 0.
- Writes: when wr_en is high, write the element at wr_addr in buffer ~front_sel, using the front_sel value in effect before any swap on that same edge.
  - Writes are allowed at any time, including while a swap is pending.
  - An out-of-range wr_addr (>= N*N) is ignored.
- Swap handshake:
  - swap_req sets the pending flag; swap_req while already pending is ignored.
  - Frame boundary = registered previous in_vsync is 1 and current in_vsync is 0.
  - At a frame boundary with pending set: front_sel toggles, pending clears, swap_ack is 1 for exactly one cycle.
  - swap_req arriving on the boundary cycle itself sets pending but is serviced at the next boundary, not this one.
  - After a swap, the new back buffer keeps its old contents; it is not cleared.
- Reset mid-frame or while pending: everything returns to reset values and no ack is issued for the dropped request.

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE=640, V_ACTIVE=480
  - COLOR_BG, COLOR_GRID
  - an rgb9 typedef with three 3-bit fields
  - the clog2 helper
- Sub-module matrix_frame_buffer holds the two register banks, the write port, the registered read port and front_sel.
- The top level holds the geometry, the swap FSM (IDLE/PENDING), the colour map and the sync delay line.

Test Plan:
- Reset: hold reset_n low mid-frame -> red/green/blue=0, hsync=vsync=1, swap_ack=0, front_sel=0 immediately, with no clock edge needed.
- Swap display (defaults N=4, CELL_PX=64, ORIGIN 64,64):
  - Write addr 6 = 8'hE0, pulse swap_req, then drop in_vsync 1->0.
  - swap_ack is high for 1 cycle and front_sel=1.
  - Pixel (200,140) active -> red=7, green=0, blue=0 three cycles later.
- Geometry:
  - Pixel (192,140) -> 7/7/7.
  - Pixel (320,320) -> 7/7/7 (closing edge).
  - Pixel (10,10) active -> 0/0/1.
  - Any pixel with in_active=0 -> 0/0/0.
- Latency: a single-cycle low on in_hsync at cycle t -> hsync is low only at cycle t+3; vsync likewise.
- Isolation: write addr 0 = 8'hFF with no swap -> pixel (70,70) stays red=0, green=7 (front buffer, element 0 = 0).
- Handshake corners:
  - Second swap_req while pending -> exactly one ack.
  - swap_req on the boundary cycle -> ack at the following boundary.
  - Reset while pending -> no ack at the next vsync edge.
